// File: rtl/ibex_instr_obi_slice_pkg.sv
// Shared widths and helpers for the instruction-fetch OBI register slice.
package ibex_instr_obi_slice_pkg;

    localparam int unsigned ObiAddrW = 32;
    localparam int unsigned ObiDataW = 32;

    // Outstanding counter must hold 0..max_out inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return (max_out < 1) ? 1 : $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/ibex_instr_obi_slice.sv
// Register slice between the prefetch buffer fetch port and instruction memory;
// registers the request path, optionally the response path, and bounds in-flight fetches.
module ibex_instr_obi_slice
    import ibex_instr_obi_slice_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          RegResp        = 1'b1,
    parameter bit          ResetAll       = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                host_req_i,
    output logic                host_gnt_o,
    input  logic [ObiAddrW-1:0] host_addr_i,
    output logic                host_rvalid_o,
    output logic [ObiDataW-1:0] host_rdata_o,
    output logic                host_err_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [ObiAddrW-1:0] mem_addr_o,
    input  logic                mem_rvalid_i,
    input  logic [ObiDataW-1:0] mem_rdata_i,
    input  logic                mem_err_i,
    output logic                busy_o
);

    localparam int unsigned     CntW   = cnt_width(MaxOutstanding);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic                req_q;
    logic                rvalid_q;
    logic [CntW-1:0]     cnt_q;
    logic [CntW-1:0]     cnt_d;
    logic [ObiAddrW-1:0] addr_q;
    logic [ObiDataW-1:0] rdata_q;
    logic                err_q;
    logic                host_hs;

    // Grant looks only at slot/counter state so it never loops back on host_req_i.
    assign host_gnt_o = (~req_q | mem_gnt_i) & (cnt_q < CntMax);
    assign host_hs    = host_req_i & host_gnt_o;

    assign host_rvalid_o = RegResp ? rvalid_q : mem_rvalid_i;
    assign host_rdata_o  = RegResp ? rdata_q  : mem_rdata_i;
    assign host_err_o    = RegResp ? err_q    : mem_err_i;

    assign cnt_d = cnt_q + CntW'(host_hs) - CntW'(host_rvalid_o);

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign busy_o     = req_q | (cnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q    <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (host_hs) begin
                req_q <= 1'b1;
            end else if (mem_gnt_i) begin
                req_q <= 1'b0;
            end
            cnt_q    <= cnt_d;
            rvalid_q <= RegResp & mem_rvalid_i;
        end
    end

    generate
        if (ResetAll) begin : g_data_rst
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    addr_q  <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end else begin
                    if (host_hs) begin
                        addr_q <= host_addr_i;
                    end
                    if (mem_rvalid_i) begin
                        rdata_q <= mem_rdata_i;
                        err_q   <= mem_err_i;
                    end
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk_i) begin
                if (host_hs) begin
                    addr_q <= host_addr_i;
                end
                if (mem_rvalid_i) begin
                    rdata_q <= mem_rdata_i;
                    err_q   <= mem_err_i;
                end
            end
        end
    endgenerate

`ifndef SYNTHESIS
    localparam int unsigned OutW = CntW + 1;

    // Requests granted by memory whose response has not come back yet.
    logic [OutW-1:0] mem_out_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_out_q <= '0;
        end else begin
            mem_out_q <= mem_out_q + OutW'(mem_req_o & mem_gnt_i) - OutW'(mem_rvalid_i);
        end
    end

    a_rvalid_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> (mem_out_q != '0));
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_req_o & ~mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o)));
    a_cnt_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CntMax);
    a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        host_rvalid_o |-> (cnt_q != '0));
    a_ctrl_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({mem_req_o, host_gnt_o, host_rvalid_o, busy_o}));
`endif

endmodule
